// File: rtl/control_unit.sv
// Multi-cycle MIPS-style control unit: Moore FSM that sequences fetch, decode
// and execute for R-type, lw, sw, beq, j and addi, halting on anything else.
module control_unit (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Operation,
    input  logic [5:0] Funct,
    output logic       pc_reset,
    output logic       instReg_reset,
    output logic       a_reset,
    output logic       b_reset,
    output logic       ALUout_reset,
    output logic       pc_load,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       instReg_load,
    output logic       IRWrite,
    output logic       a_load,
    output logic       b_load,
    output logic       ALUout_load,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALU_select,
    output logic [3:0] State,
    output logic       Halted
);

    typedef enum logic [3:0] {
        S_RESET      = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC_R     = 4'd4,
        S_ALU_WB     = 4'd5,
        S_MEM_ADDR   = 4'd6,
        S_MEM_READ   = 4'd7,
        S_MEM_WAIT   = 4'd8,
        S_MEM_WB     = 4'd9,
        S_MEM_WRITE  = 4'd10,
        S_BRANCH     = 4'd11,
        S_JUMP       = 4'd12,
        S_ADDI_EXEC  = 4'd13,
        S_ADDI_WB    = 4'd14,
        S_HALT       = 4'd15
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] funct_q;
    logic [2:0] r_alu;
    logic       r_ok;

    // Funct is captured in DECODE so EXEC_R outputs depend only on registered state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_RESET;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                funct_q <= Funct;
            end
        end
    end

    always_comb begin
        r_alu = 3'b000;
        r_ok  = 1'b1;
        case (funct_q)
            6'h20:   r_alu = 3'b001;
            6'h22:   r_alu = 3'b010;
            6'h24:   r_alu = 3'b011;
            6'h25:   r_alu = 3'b100;
            6'h2A:   r_alu = 3'b111;
            default: r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:      state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                case (Operation)
                    6'h00:        state_d = (Funct == 6'h0D) ? S_HALT : S_EXEC_R;
                    6'h23, 6'h2B: state_d = S_MEM_ADDR;
                    6'h04:        state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    6'h08:        state_d = S_ADDI_EXEC;
                    default:      state_d = S_HALT;
                endcase
            end
            S_EXEC_R:     state_d = r_ok ? S_ALU_WB : S_HALT;
            S_ALU_WB:     state_d = S_FETCH;
            S_MEM_ADDR:   state_d = (Operation == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:   state_d = S_MEM_WAIT;
            S_MEM_WAIT:   state_d = S_MEM_WB;
            S_MEM_WB:     state_d = S_FETCH;
            S_MEM_WRITE:  state_d = S_FETCH;
            S_BRANCH:     state_d = S_FETCH;
            S_JUMP:       state_d = S_FETCH;
            S_ADDI_EXEC:  state_d = S_ADDI_WB;
            S_ADDI_WB:    state_d = S_FETCH;
            S_HALT:       state_d = S_HALT;
            default:      state_d = S_RESET;
        endcase
    end

    always_comb begin
        pc_reset      = 1'b0;
        instReg_reset = 1'b0;
        a_reset       = 1'b0;
        b_reset       = 1'b0;
        ALUout_reset  = 1'b0;
        pc_load       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        instReg_load  = 1'b0;
        IRWrite       = 1'b0;
        a_load        = 1'b0;
        b_load        = 1'b0;
        ALUout_load   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        RegWrite      = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALU_select    = 3'b000;
        Halted        = 1'b0;
        case (state_q)
            S_RESET: begin
                pc_reset      = 1'b1;
                instReg_reset = 1'b1;
                a_reset       = 1'b1;
                b_reset       = 1'b1;
                ALUout_reset  = 1'b1;
            end
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                ALU_select = 3'b001;
                PCWrite    = 1'b1;
                pc_load    = 1'b1;
            end
            S_FETCH_WAIT: begin
                MemRead      = 1'b1;
                IRWrite      = 1'b1;
                instReg_load = 1'b1;
            end
            S_DECODE: begin
                a_load      = 1'b1;
                b_load      = 1'b1;
                ALUSrcB     = 2'b11;
                ALU_select  = 3'b001;
                ALUout_load = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA     = 1'b1;
                ALUout_load = 1'b1;
                ALU_select  = r_alu;
            end
            S_ALU_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALU_select  = 3'b001;
                ALUout_load = 1'b1;
            end
            S_MEM_READ, S_MEM_WAIT: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_select  = 3'b010;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
                pc_load     = 1'b1;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                pc_load  = 1'b1;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                Halted = 1'b0;
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: expected per-cycle control words are queued as each
// instruction is issued and compared against the DUT one cycle at a time.
module tb_control_unit;

    logic       Clk;
    logic       Reset_n;
    logic [5:0] Operation;
    logic [5:0] Funct;
    logic       pc_reset, instReg_reset, a_reset, b_reset, ALUout_reset;
    logic       pc_load, PCWrite, PCWriteCond, instReg_load, IRWrite;
    logic       a_load, b_load, ALUout_load;
    logic       IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALU_select;
    logic [3:0] State;
    logic       Halted;

    logic [31:0] obs_word;
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    control_unit dut (
        .Clk(Clk), .Reset_n(Reset_n), .Operation(Operation), .Funct(Funct),
        .pc_reset(pc_reset), .instReg_reset(instReg_reset), .a_reset(a_reset),
        .b_reset(b_reset), .ALUout_reset(ALUout_reset),
        .pc_load(pc_load), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .instReg_load(instReg_load), .IRWrite(IRWrite), .a_load(a_load),
        .b_load(b_load), .ALUout_load(ALUout_load),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALU_select(ALU_select),
        .State(State), .Halted(Halted)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign obs_word = {State, Halted,
                       pc_reset, instReg_reset, a_reset, b_reset, ALUout_reset,
                       pc_load, PCWrite, PCWriteCond, instReg_load, IRWrite,
                       a_load, b_load, ALUout_load,
                       IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
                       ALUSrcB, PCSource, ALU_select};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // Reference control word for a state, written from the state table.
    function automatic logic [31:0] exp_word(input logic [3:0] st, input logic [2:0] r_alu);
        logic       h, rst, pcl, pcw, pcwc, irl, irw, al, bl, aol;
        logic       iord, mr, mw, rw, rd, m2r, asa;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        {h, rst, pcl, pcw, pcwc, irl, irw, al, bl, aol} = '0;
        {iord, mr, mw, rw, rd, m2r, asa} = '0;
        asb = 2'b00; pcs = 2'b00; alu = 3'b000;
        case (st)
            4'd0:  rst = 1'b1;
            4'd1:  begin mr = 1'b1; asb = 2'b01; alu = 3'b001; pcw = 1'b1; pcl = 1'b1; end
            4'd2:  begin mr = 1'b1; irw = 1'b1; irl = 1'b1; end
            4'd3:  begin al = 1'b1; bl = 1'b1; asb = 2'b11; alu = 3'b001; aol = 1'b1; end
            4'd4:  begin asa = 1'b1; aol = 1'b1; alu = r_alu; end
            4'd5:  begin rd = 1'b1; rw = 1'b1; end
            4'd6:  begin asa = 1'b1; asb = 2'b10; alu = 3'b001; aol = 1'b1; end
            4'd7:  begin iord = 1'b1; mr = 1'b1; end
            4'd8:  begin iord = 1'b1; mr = 1'b1; end
            4'd9:  begin m2r = 1'b1; rw = 1'b1; end
            4'd10: begin iord = 1'b1; mw = 1'b1; end
            4'd11: begin asa = 1'b1; alu = 3'b010; pcs = 2'b01; pcwc = 1'b1; pcl = 1'b1; end
            4'd12: begin pcs = 2'b10; pcw = 1'b1; pcl = 1'b1; end
            4'd13: begin asa = 1'b1; asb = 2'b10; alu = 3'b001; aol = 1'b1; end
            4'd14: rw = 1'b1;
            default: h = 1'b1;
        endcase
        return {st, h, {5{rst}}, pcl, pcw, pcwc, irl, irw, al, bl, aol,
                iord, mr, mw, rw, rd, m2r, asa, asb, pcs, alu};
    endfunction

    task automatic push_state(input logic [3:0] st, input logic [2:0] r_alu);
        exp_q.push_back(exp_word(st, r_alu));
    endtask

    // Drain the queue one cycle at a time; opcode/funct are scrambled once the
    // FSM has moved past the last state that may sample them.
    task automatic run_queue(input int scr_idx);
        int k;
        logic [31:0] e;
        k = 0;
        while (exp_q.size() > 0) begin
            if (k == scr_idx) begin
                Operation = 6'($urandom_range(0, 63));
                Funct     = 6'($urandom_range(0, 63));
            end
            e = exp_q.pop_front();
            check_eq("state_word", obs_word, e);
            check_eq("mem_rd_wr_excl", {31'b0, MemRead & MemWrite}, 32'd0);
            check_eq("pcw_excl", {31'b0, PCWrite & PCWriteCond}, 32'd0);
            @(negedge Clk);
            k++;
        end
    endtask

    // Driver: issue one instruction from FETCH; returns 1 if it should halt.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, output bit halted);
        int         scr;
        logic [2:0] alu;
        bit         ok;
        Operation = op;
        Funct     = fn;
        halted    = 1'b0;
        scr       = 99;
        push_state(4'd1, 3'd0);
        push_state(4'd2, 3'd0);
        push_state(4'd3, 3'd0);
        case (op)
            6'h00: begin
                if (fn == 6'h0D) begin
                    push_state(4'd15, 3'd0);
                    halted = 1'b1;
                end else begin
                    ok = 1'b1;
                    case (fn)
                        6'h20:   alu = 3'b001;
                        6'h22:   alu = 3'b010;
                        6'h24:   alu = 3'b011;
                        6'h25:   alu = 3'b100;
                        6'h2A:   alu = 3'b111;
                        default: begin alu = 3'b000; ok = 1'b0; end
                    endcase
                    push_state(4'd4, alu);
                    if (ok) begin
                        push_state(4'd5, 3'd0);
                        scr = 4;
                    end else begin
                        push_state(4'd15, 3'd0);
                        halted = 1'b1;
                    end
                end
            end
            6'h23: begin
                push_state(4'd6, 3'd0); push_state(4'd7, 3'd0);
                push_state(4'd8, 3'd0); push_state(4'd9, 3'd0);
                scr = 4;
            end
            6'h2B: begin push_state(4'd6, 3'd0); push_state(4'd10, 3'd0); scr = 4; end
            6'h04: begin push_state(4'd11, 3'd0); scr = 3; end
            6'h02: begin push_state(4'd12, 3'd0); scr = 3; end
            6'h08: begin push_state(4'd13, 3'd0); push_state(4'd14, 3'd0); scr = 3; end
            default: begin push_state(4'd15, 3'd0); halted = 1'b1; end
        endcase
        run_queue(scr);
    endtask

    // Reset pulled low between clock edges; must take effect before the next edge.
    task automatic async_reset();
        #2 Reset_n = 1'b0;
        #1 check_eq("async_rst", obs_word, exp_word(4'd0, 3'd0));
        @(negedge Clk);
        check_eq("rst_held", obs_word, exp_word(4'd0, 3'd0));
        Reset_n = 1'b1;
        #1 check_eq("rst_release", obs_word, exp_word(4'd0, 3'd0));
        @(negedge Clk);
    endtask

    logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    logic [5:0] fns[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        bit h;
        int sel;
        Reset_n   = 1'b0;
        Operation = 6'h00;
        Funct     = 6'h00;
        #3 check_eq("reset_state", obs_word, exp_word(4'd0, 3'd0));
        @(negedge Clk);
        Reset_n = 1'b1;
        #1 check_eq("reset_release", obs_word, exp_word(4'd0, 3'd0));
        @(negedge Clk);

        // every supported instruction once, then a random mix
        for (int i = 0; i < 10; i++) begin
            do_instr(ops[i], fns[i], h);
            check_eq("no_halt", {31'b0, h}, 32'd0);
        end
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            do_instr(ops[sel], fns[sel], h);
        end

        // illegal opcode halts and stays halted
        do_instr(6'h3F, 6'h00, h);
        for (int i = 0; i < 20; i++) begin
            Operation = 6'($urandom_range(0, 63));
            Funct     = 6'($urandom_range(0, 63));
            check_eq("halt_hold", obs_word, exp_word(4'd15, 3'd0));
            @(negedge Clk);
        end
        async_reset();

        // halt funct from DECODE, bad funct from EXEC_R
        do_instr(6'h00, 6'h0D, h);
        check_eq("halt_0d", obs_word, exp_word(4'd15, 3'd0));
        async_reset();
        do_instr(6'h00, 6'h3F, h);
        check_eq("halt_3f", obs_word, exp_word(4'd15, 3'd0));
        async_reset();

        // reset in the middle of a load
        Operation = 6'h23;
        Funct     = 6'h00;
        push_state(4'd1, 3'd0); push_state(4'd2, 3'd0); push_state(4'd3, 3'd0);
        push_state(4'd6, 3'd0); push_state(4'd7, 3'd0);
        run_queue(99);
        async_reset();
        do_instr(6'h02, 6'h00, h);
        do_instr(6'h00, 6'h2A, h);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: Clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have port: Reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: Operation  in  6  opcode field (instruction[31:26]) from the datapath instruction register.
REQ-004 SHALL have port: Funct  in  6  function field (instruction[5:0]), used only when Operation=6'h00.
REQ-005 SHALL have ports: pc_reset, instReg_reset, a_reset, b_reset, ALUout_reset  out  1 each  register clears.
REQ-006 SHALL have ports: pc_load, PCWrite, PCWriteCond, instReg_load, IRWrite, a_load, b_load, ALUout_load  out  1 each  register enables.
REQ-007 SHALL have ports: IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA  out  1 each  datapath selects/strobes.
REQ-008 SHALL have ports: ALUSrcB  out  2, PCSource  out  2 (00 ALU result, 01 ALUout, 10 jump target), ALU_select  out  3.
REQ-009 SHALL have ports: State  out  4  current state code; Halted  out  1  sticky halt flag.

Function
REQ-010 SHALL be a Moore FSM; every output is a pure function of the state register.
REQ-011 SHALL encode states: RESET=0, FETCH=1, FETCH_WAIT=2, DECODE=3, EXEC_R=4, ALU_WB=5, MEM_ADDR=6, MEM_READ=7, MEM_WAIT=8, MEM_WB=9, MEM_WRITE=10, BRANCH=11, JUMP=12, ADDI_EXEC=13, ADDI_WB=14, HALT=15.
REQ-012 SHALL assert every output not listed for a state as 0.
REQ-013 RESET: all five *_reset=1; next FETCH.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_select=001 (add), PCSource=00, PCWrite=1, pc_load=1; next FETCH_WAIT.
REQ-015 FETCH_WAIT: MemRead=1, IRWrite=1, instReg_load=1; next DECODE.
REQ-016 DECODE: a_load=1, b_load=1, ALUSrcA=0, ALUSrcB=11, ALU_select=001, ALUout_load=1; next selected by Operation per REQ-017.
REQ-017 Dispatch: 00->EXEC_R (Funct 0x0D ->HALT); 23/2B->MEM_ADDR; 04->BRANCH; 02->JUMP; 08->ADDI_EXEC; any other opcode->HALT.
REQ-018 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUout_load=1, ALU_select from Funct: 20->001, 22->010, 24->011, 25->100, 2A->111, other->HALT next instead of ALU_WB.
REQ-019 ALU_WB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-020 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_select=001, ALUout_load=1; next MEM_READ if Operation=23 else MEM_WRITE.
REQ-021 MEM_READ: IorD=1, MemRead=1; next MEM_WAIT. MEM_WAIT: IorD=1, MemRead=1; next MEM_WB.
REQ-022 MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-023 MEM_WRITE: IorD=1, MemWrite=1; next FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_select=010, PCSource=01, PCWriteCond=1, pc_load=1; next FETCH.
REQ-025 JUMP: PCSource=10, PCWrite=1, pc_load=1; next FETCH.
REQ-026 ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALU_select=001, ALUout_load=1; next ADDI_WB. ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-027 HALT: Halted=1, no strobes; remains in HALT until Reset_n low.
REQ-028 Cycle counts FETCH-to-FETCH SHALL be: R/addi 5, lw 7, sw 5, beq 4, j 4.
REQ-029 MemRead and MemWrite SHALL never be 1 in the same cycle; PCWrite and PCWriteCond SHALL never be 1 together.
REQ-030 Operation/Funct SHALL be sampled only in DECODE, EXEC_R and MEM_ADDR; changes elsewhere have no effect.

Reset
REQ-031 Reset_n low SHALL force State=RESET immediately (asynchronous), independent of Clk, including mid-instruction and from HALT.
REQ-032 While Reset_n low: all *_reset=1, Halted=0, all other outputs 0; first rising edge after release enters FETCH.

Verification
REQ-033 Reset release, Operation=00, Funct=20 -> State sequence 0,1,2,3,4,5,1; RegWrite=1,RegDst=1 only in state 5; ALU_select=001 in state 4.
REQ-034 Operation=23 -> 3,6,7,8,9,1; MemRead=1 and IorD=1 in states 7,8; MemtoReg=1,RegWrite=1 in 9.
REQ-035 Operation=2B -> 3,6,10,1; MemWrite=1 exactly one cycle; MemRead=0 throughout 6,10.
REQ-036 Operation=04 then 02 -> BRANCH with PCWriteCond=1,PCSource=01,ALU_select=010; JUMP with PCWrite=1,PCSource=10; each 4 cycles.
REQ-037 Operation=3F in DECODE -> State=15, Halted=1 held 20 cycles; Reset_n pulsed low mid-cycle -> State=0 before next edge, Halted=0.
REQ-038 Operation=00, Funct=0D -> HALT from DECODE; Funct=3F -> HALT from EXEC_R with RegWrite never asserted.
